vedic_mul8_seq_ctrl: RTL
========================

// Module: vedic_mul8_seq_ctrl
// PURPOSE
// - Area-reduced 8x8 unsigned Vedic multiplier controller. It time-shares one 4x4 Vedic multiplier across
//   the four nibble cross-products and accumulates them into a 16-bit product.
// - Sits between the operand source and the product sink, with valid/ready on both sides.
// - Alternative to the fully parallel four-multiplier + CSA tree when area matters more than throughput.
// PARAMETERS
// - PP_REG  default 0  1 = register the 4x4 partial product before accumulation (+1 cycle per step)
// PORTS
// - clk        in   1   single clock, rising edge
// - rst_n      in   1   asynchronous, active-low reset
// - flush      in   1   synchronous abort; drops the operation in flight
// - in_valid   in   1   operands a/b valid
// - in_ready   out  1   block accepts operands this cycle
// - a          in   8   multiplicand, unsigned
// - b          in   8   multiplier, unsigned
// - out_valid  out  1   p valid
// - out_ready  in   1   sink accepts p this cycle
// - p          out  16  product a*b
// - busy       out  1   operation in flight (state != IDLE)
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, acc=0, operand regs=0, out_valid=0, busy=0, p=0.
// - FSM states: IDLE, MUL0, MUL1, MUL2, MUL3, DONE.
// - If PP_REG=1, each MULk is followed by a WAITk cycle before its add, giving 8 step cycles.
// - Accept: in_valid && in_ready. Latch a/b, clear acc, go to MUL0.
// - in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
// - Step schedule (4x4 mul inputs, acc update at step end):
//   - MUL0: a[3:0]*b[3:0], acc += pp
//   - MUL1: a[7:4]*b[3:0], acc += pp<<4
//   - MUL2: a[3:0]*b[7:4], acc += pp<<4
//   - MUL3: a[7:4]*b[7:4], acc += pp<<8; then go to DONE
// - Widths: pp is 8 bits. Shifted pp is zero-extended to 16 bits. acc is 16 bits.
//   No overflow is possible, since 255*255=0xFE01.
// - DONE: out_valid=1, p=acc. Both are held stable until out_ready.
//   - out_ready && in_valid: accept the new operands the same cycle and go to MUL0 (back-to-back).
//   - out_ready && !in_valid: go to IDLE.
// - Latency: out_valid rises 4 clocks after the accept edge (8 when PP_REG=1).
// - Peak throughput: one result per 5 clocks (9 when PP_REG=1).
// - out_valid=0 in every state except DONE. p is held at its last value when out_valid=0.
// - busy=1 in every state except IDLE.
// - flush (sync) in any state: go to IDLE next edge, out_valid=0, acc=0.
//   - A result in DONE is discarded even if out_ready=1 that cycle.
//   - flush blocks accept because in_ready is forced low.
// - Reset mid-operation: immediate return to reset values. No partial result is emitted.
// - Operands change while busy: ignored, because only the latched copies are used.
// STRUCTURE
// - Shared package vedic_pkg:
//   - typedef enum logic [2:0] vmul_state_e {IDLE, MUL0, MUL1, MUL2, MUL3, DONE}
//   - PP_REG wait encoding
//   - localparams NIB_W=4, OP_W=8, PROD_W=16
// - One sub-module: vedic_4x4_mul (combinational 4x4 Vedic multiplier, 8-bit out), instantiated once.
//   Its operands are muxed from the latched nibbles by state.
// - Accumulator add: plain 16-bit adder in this module. No CSA is needed, since there are only two operands per step.
// TESTING
// - Corners: a=0xFF, b=0xFF -> p=0xFE01, out_valid exactly 4 clocks after accept.
//   a=0x00, b=0xA5 -> 0x0000. a=0x01, b=0x01 -> 0x0001.
// - Backpressure: hold out_ready=0 for 10 clocks in DONE.
//   -> p, out_valid stable; in_ready=0; in_valid pulses are not accepted.
// - Back-to-back: 0x12*0x34 then 0xAB*0xCD with out_ready=1, in_valid=1.
//   -> 0x03A8, then 0x88EF. Second accept on the same edge as the first output handshake.
// - Flush at MUL2 with a=0x9C, b=0x7E -> IDLE next clock, out_valid never rises.
//   Next op 0x10*0x10 -> 0x0100.
// - Async reset asserted mid-MUL1 (between clock edges) -> outputs reset immediately.
//   After release, a new op 0x0F*0xF0 -> 0x0E10.
// - PP_REG=1 build: 0xFF*0xFF -> 0xFE01 after 8 clocks.
//   Random 1000 ops with random valid/ready -> every p equals a*b, none lost or duplicated.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential 8x8 Vedic multiplier controller.
// Provides the controller state encoding, the pipeline phase encoding used
// when the partial product is registered, the datapath widths, and the
// step-successor helper for the MULk states.
package vedic_pkg;

   localparam int NIB_W  = 4;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL0 = 3'd1,
      MUL1 = 3'd2,
      MUL2 = 3'd3,
      MUL3 = 3'd4,
      DONE = 3'd5
   } vmul_state_e;

   // With a registered partial product every MULk spends one cycle in
   // PH_MUL (capture pp) and one in PH_WAIT (accumulate it).
   typedef enum logic {
      PH_MUL  = 1'b0,
      PH_WAIT = 1'b1
   } vmul_phase_e;

   // Successor of a multiply step; MUL3 completes the product.
   function automatic vmul_state_e next_mul_state(input vmul_state_e cur);
      vmul_state_e nxt;
      case (cur)
         MUL0:    nxt = MUL1;
         MUL1:    nxt = MUL2;
         MUL2:    nxt = MUL3;
         MUL3:    nxt = DONE;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/vedic_4x4_mul.sv
// Combinational 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier.
// Built from four 2x2 Vedic blocks whose results are summed with their
// nibble-position weights.
// Ports:
//   x    in  4  operand
//   y    in  4  operand
//   prod out 8  x*y
module vedic_4x4_mul
   import vedic_pkg::*;
(
   input  logic [NIB_W-1:0]   x,
   input  logic [NIB_W-1:0]   y,
   output logic [2*NIB_W-1:0] prod
);

   // 2x2 Vedic cell: vertical and crosswise products with a half-adder chain.
   function automatic logic [3:0] vedic_2x2(input logic [1:0] u, input logic [1:0] v);
      logic       c;
      logic [3:0] r;
      r[0] = u[0] & v[0];
      r[1] = (u[1] & v[0]) ^ (u[0] & v[1]);
      c    = (u[1] & v[0]) & (u[0] & v[1]);
      r[2] = (u[1] & v[1]) ^ c;
      r[3] = (u[1] & v[1]) & c;
      return r;
   endfunction

   logic [3:0] q_ll_s;
   logic [3:0] q_hl_s;
   logic [3:0] q_lh_s;
   logic [3:0] q_hh_s;

   // Four 2x2 cross-products and their weighted sum.
   always_comb begin
      q_ll_s = vedic_2x2(x[1:0], y[1:0]);
      q_hl_s = vedic_2x2(x[3:2], y[1:0]);
      q_lh_s = vedic_2x2(x[1:0], y[3:2]);
      q_hh_s = vedic_2x2(x[3:2], y[3:2]);
      prod   = {4'h0, q_ll_s}
             + {2'b00, q_hl_s, 2'b00}
             + {2'b00, q_lh_s, 2'b00}
             + {q_hh_s, 4'h0};
   end

endmodule

// File: rtl/vedic_mul8_seq_ctrl.sv
// Area-reduced 8x8 unsigned multiplier: one shared 4x4 Vedic multiplier is
// stepped across the four nibble cross-products and accumulated into a
// 16-bit product. Valid/ready handshakes on operand and product sides.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous abort of the operation in flight
//   in_valid/in_ready   operand handshake, a and b unsigned 8-bit
//   out_valid/out_ready product handshake, p is 16-bit a*b
//   busy                operation in flight
// Parameter PP_REG=1 registers the 4x4 product before each add.
module vedic_mul8_seq_ctrl
   import vedic_pkg::*;
#(
   parameter bit PP_REG = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p,
   output logic              busy
);

   vmul_state_e          state_r;
   vmul_state_e          state_nx_s;
   vmul_phase_e          phase_r;
   vmul_phase_e          phase_nx_s;
   logic [OP_W-1:0]      a_r;
   logic [OP_W-1:0]      b_r;
   logic [PROD_W-1:0]    acc_r;
   logic [OP_W-1:0]      pp_r;
   logic [PROD_W-1:0]    p_r;
   logic                 out_valid_r;
   logic                 busy_r;
   logic [NIB_W-1:0]     mul_x_s;
   logic [NIB_W-1:0]     mul_y_s;
   logic [OP_W-1:0]      pp_s;
   logic [OP_W-1:0]      pp_use_s;
   logic [PROD_W-1:0]    addend_s;
   logic [PROD_W-1:0]    acc_sum_s;
   logic                 in_mul_s;
   logic                 accept_s;
   logic                 step_add_s;
   logic                 out_valid_nx_s;
   logic                 busy_nx_s;

   assign in_ready  = !flush && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
   assign accept_s  = in_valid && in_ready;
   assign in_mul_s  = (state_r == MUL0) || (state_r == MUL1) ||
                      (state_r == MUL2) || (state_r == MUL3);
   // An add happens at the end of the step; flush suppresses it.
   assign step_add_s = !flush && in_mul_s && (!PP_REG || (phase_r == PH_WAIT));
   assign pp_use_s   = PP_REG ? pp_r : pp_s;
   assign acc_sum_s  = acc_r + addend_s;

   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign p         = p_r;

   vedic_4x4_mul u_mul (
      .x    (mul_x_s),
      .y    (mul_y_s),
      .prod (pp_s)
   );

   // Nibble operand select and partial-product weighting by step.
   always_comb begin
      mul_x_s  = 4'h0;
      mul_y_s  = 4'h0;
      addend_s = 16'h0000;
      case (state_r)
         MUL0: begin
            mul_x_s  = a_r[3:0];
            mul_y_s  = b_r[3:0];
            addend_s = {8'h00, pp_use_s};
         end
         MUL1: begin
            mul_x_s  = a_r[7:4];
            mul_y_s  = b_r[3:0];
            addend_s = {4'h0, pp_use_s, 4'h0};
         end
         MUL2: begin
            mul_x_s  = a_r[3:0];
            mul_y_s  = b_r[7:4];
            addend_s = {4'h0, pp_use_s, 4'h0};
         end
         MUL3: begin
            mul_x_s  = a_r[7:4];
            mul_y_s  = b_r[7:4];
            addend_s = {pp_use_s, 8'h00};
         end
         default: begin
            mul_x_s  = 4'h0;
            mul_y_s  = 4'h0;
            addend_s = 16'h0000;
         end
      endcase
   end

   // FSM state and phase register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         phase_r <= PH_MUL;
      end else begin
         state_r <= state_nx_s;
         phase_r <= phase_nx_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      phase_nx_s = PH_MUL;
      if (flush) begin
         state_nx_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) state_nx_s = MUL0;
               else          state_nx_s = IDLE;
            end
            MUL0, MUL1, MUL2, MUL3: begin
               if (PP_REG && (phase_r == PH_MUL)) phase_nx_s = PH_WAIT;
               else                               state_nx_s = next_mul_state(state_r);
            end
            DONE: begin
               if (out_ready) state_nx_s = in_valid ? MUL0 : IDLE;
               else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // FSM output decode, registered below so the outputs track the state.
   always_comb begin
      out_valid_nx_s = (state_nx_s == DONE);
      busy_nx_s      = (state_nx_s != IDLE);
   end

   // Operand latches, partial-product register and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= 8'h00;
         b_r   <= 8'h00;
         pp_r  <= 8'h00;
         acc_r <= 16'h0000;
      end else begin
         if (accept_s) begin
            a_r <= a;
            b_r <= b;
         end
         if (phase_r == PH_MUL) pp_r <= pp_s;
         if (flush || accept_s) acc_r <= 16'h0000;
         else if (step_add_s)   acc_r <= acc_sum_s;
      end
   end

   // Registered outputs; p keeps its last value until a new product completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         p_r         <= 16'h0000;
      end else begin
         out_valid_r <= out_valid_nx_s;
         busy_r      <= busy_nx_s;
         if (step_add_s && (state_r == MUL3)) p_r <= acc_sum_s;
      end
   end

endmodule
